// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor, transmitter state encoding, frame lengths.
// Defining UART_TX_PARITY_EN adds the PARITY state and lengthens the frame to 11 bits.
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
    localparam int FRAME_BITS = 10;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

    // Clock cycles per line bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign wr_ok   = push && !full;
    assign rd_ok   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array carries no reset; level gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: CPU pushes bytes into a FIFO, the FSM drains them back-to-back.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          write_en,
    input  logic [7:0]                    write_data,
    input  logic                          ovf_clr,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int BW       = $clog2(BAUD_DIV + 1);

    tx_state_e   state;
    tx_state_e   state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_data;
    logic [7:0]  fifo_rd_data;
    logic        tx_next;
    logic        pop;
    logic        push;
    logic        bit_done;
    logic        rst_done;

    // Pushes are blocked for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    assign push     = write_en && rst_done;
    assign bit_done = (baud_cnt == BW'(BAUD_DIV - 1));
    assign tx_busy  = (state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (write_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_next    = uart_tx;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    tx_next    = tx_data[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = ^tx_data;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = tx_data[bit_cnt + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_data  <= '0;
        end else begin
            uart_tx  <= tx_next;
            baud_cnt <= (state == IDLE || bit_done) ? '0 : baud_cnt + 1'b1;
            if (pop) tx_data <= fifo_rd_data;
            if (state != DATA)  bit_cnt <= '0;
            else if (bit_done)  bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // A dropped push outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   overflow <= 1'b0;
        else if (push && fifo_full)   overflow <= 1'b1;
        else if (ovf_clr)             overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 1 MHz / 100 kbaud (10 cycles per bit), FIFO_DEPTH 16.
// Compile with UART_TX_PARITY_EN to exercise the parity frame as well.
module tb_uart_tx_buffered;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_CYC    = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_en;
    logic [7:0] write_data;
    logic       ovf_clr;
    logic       uart_tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_level;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write_en   (write_en),
        .write_data (write_data),
        .ovf_clr    (ovf_clr),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        write_en   = 1'b1;
        write_data = d;
        tick();
        write_en   = 1'b0;
        write_data = 8'hE7;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0)                            return 1'b0;
        if (b <= 8)                            return d[b-1];
        if (b == 9 && FRAME_BITS == 11)        return ^d;
        return 1'b1;
    endfunction

    // Follows one frame from its start edge, one comparison per line bit covering every cycle of it.
    // Leaves the bench #1 after the edge that ends the stop bit.
    task automatic watch_frame(input logic [7:0] d, input int skip, input bit push_last);
        logic exp;
        logic bad;
        logic bad_tx;
        logic bad_busy;
        bad = 1'b0;
        bad_tx = 1'b0;
        bad_busy = 1'b0;
        for (int c = skip; c < FRAME_BITS * BIT_CYC; c++) begin
            exp = frame_bit(d, c / BIT_CYC);
            if (!bad && (uart_tx !== exp || tx_busy !== 1'b1)) begin
                bad      = 1'b1;
                bad_tx   = uart_tx;
                bad_busy = tx_busy;
            end
            if (c % BIT_CYC == BIT_CYC - 1) begin
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL frame 0x%02h bit %0d: uart_tx=%b tx_busy=%b, expected uart_tx=%b tx_busy=1",
                             d, c / BIT_CYC, bad_tx, bad_busy, exp);
                end
                bad = 1'b0;
            end
            if (push_last && c == FRAME_BITS * BIT_CYC - 1) begin
                write_en   = 1'b1;
                write_data = 8'hCC;
            end
            tick();
            write_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        write_en   = 1'b0;
        write_data = 8'h00;
        ovf_clr    = 1'b0;
        repeat (3) tick();
        checks++; if (uart_tx !== 1'b1)     begin errors++; $display("FAIL reset uart_tx: got %b want 1", uart_tx); end
        checks++; if (tx_busy !== 1'b0)     begin errors++; $display("FAIL reset tx_busy: got %b want 0", tx_busy); end
        checks++; if (fifo_level !== 5'd0)  begin errors++; $display("FAIL reset fifo_level: got %0d want 0", fifo_level); end
        checks++; if (fifo_empty !== 1'b1)  begin errors++; $display("FAIL reset fifo_empty: got %b want 1", fifo_empty); end
        checks++; if (fifo_full !== 1'b0)   begin errors++; $display("FAIL reset fifo_full: got %b want 0", fifo_full); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
        // The push in the first cycle after release must be ignored.
        rst_n = 1'b1;
        push_byte(8'h99);
        checks++; if (fifo_empty !== 1'b1)  begin errors++; $display("FAIL release push ignored: fifo_empty=%b want 1", fifo_empty); end
        tick();
        checks++; if (tx_busy !== 1'b0 || uart_tx !== 1'b1)
            begin errors++; $display("FAIL release idle: tx_busy=%b uart_tx=%b want 0/1", tx_busy, uart_tx); end
        repeat (3) tick();
    endtask

    task automatic test_single_frame();
        push_byte(8'h55);
        checks++; if (fifo_level !== 5'd1)  begin errors++; $display("FAIL single level after push: got %0d want 1", fifo_level); end
        checks++; if (uart_tx !== 1'b1)     begin errors++; $display("FAIL single line before pop: got %b want 1", uart_tx); end
        tick();
        checks++; if (fifo_level !== 5'd0)  begin errors++; $display("FAIL single level after pop: got %0d want 0", fifo_level); end
        watch_frame(8'h55, 0, 1'b0);
        checks++; if (tx_busy !== 1'b0)     begin errors++; $display("FAIL single tx_busy at end: got %b want 0", tx_busy); end
        checks++; if (uart_tx !== 1'b1)     begin errors++; $display("FAIL single idle line: got %b want 1", uart_tx); end
        tick();
    endtask

    task automatic test_back_to_back();
        push_byte(8'h01);
        checks++; if (fifo_level !== 5'd1)  begin errors++; $display("FAIL b2b level #1: got %0d want 1", fifo_level); end
        push_byte(8'h02);
        checks++; if (fifo_level !== 5'd1)  begin errors++; $display("FAIL b2b level push+pop: got %0d want 1", fifo_level); end
        push_byte(8'h03);
        checks++; if (fifo_level !== 5'd2)  begin errors++; $display("FAIL b2b level peak: got %0d want 2", fifo_level); end
        watch_frame(8'h01, 1, 1'b0);
        checks++; if (fifo_level !== 5'd1)  begin errors++; $display("FAIL b2b level after 2nd pop: got %0d want 1", fifo_level); end
        watch_frame(8'h02, 0, 1'b0);
        watch_frame(8'h03, 0, 1'b0);
        checks++; if (tx_busy !== 1'b0 || fifo_empty !== 1'b1)
            begin errors++; $display("FAIL b2b drained: tx_busy=%b fifo_empty=%b want 0/1", tx_busy, fifo_empty); end
        tick();
    endtask

    task automatic test_overflow();
        int start_cyc;
        push_byte(8'hA0);
        tick();
        start_cyc = cyc;
        for (int i = 0; i < FIFO_DEPTH; i++) push_byte(8'h10 + 8'(i));
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf level full: got %0d want 16", fifo_level); end
        checks++; if (fifo_full !== 1'b1)   begin errors++; $display("FAIL ovf fifo_full: got %b want 1", fifo_full); end
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf early flag: got %b want 0", overflow); end
        push_byte(8'hEE);
        checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf 17th push flag: got %b want 1", overflow); end
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf level capped: got %0d want 16", fifo_level); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL ovf clear: got %b want 0", overflow); end
        ovf_clr = 1'b1; push_byte(8'hDD); ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf set wins over clear: got %b want 1", overflow); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        // Push on the edge that pops the next byte while still full: still dropped.
        watch_frame(8'hA0, cyc - start_cyc, 1'b1);
        checks++; if (overflow !== 1'b1)    begin errors++; $display("FAIL ovf push during pop: got %b want 1", overflow); end
        checks++; if (fifo_level !== 5'd15) begin errors++; $display("FAIL ovf level after pop: got %0d want 15", fifo_level); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) watch_frame(8'h10 + 8'(i), (i == 0) ? 1 : 0, 1'b0);
        checks++; if (tx_busy !== 1'b0 || fifo_empty !== 1'b1)
            begin errors++; $display("FAIL ovf drained: tx_busy=%b fifo_empty=%b want 0/1", tx_busy, fifo_empty); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic bad;
        push_byte(8'h00);
        push_byte(8'h81);
        repeat (35) tick();
        checks++; if (uart_tx !== 1'b0)     begin errors++; $display("FAIL midreset precondition line: got %b want 0", uart_tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (uart_tx !== 1'b1)     begin errors++; $display("FAIL midreset uart_tx: got %b want 1", uart_tx); end
        checks++; if (tx_busy !== 1'b0)     begin errors++; $display("FAIL midreset tx_busy: got %b want 0", tx_busy); end
        checks++; if (fifo_level !== 5'd0)  begin errors++; $display("FAIL midreset fifo_level: got %0d want 0", fifo_level); end
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL midreset residual activity: saw line/busy/level change, want idle"); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        push_byte(8'h07);
        tick();
        watch_frame(8'h07, 0, 1'b0);
        checks++; if (tx_busy !== 1'b0)     begin errors++; $display("FAIL parity 0x07 frame length: tx_busy=%b want 0", tx_busy); end
        push_byte(8'h03);
        tick();
        watch_frame(8'h03, 0, 1'b0);
        checks++; if (tx_busy !== 1'b0)     begin errors++; $display("FAIL parity 0x03 frame length: tx_busy=%b want 0", tx_busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
